instruction_encoder: RTL and testbench
======================================

INSTRUCTION_ENCODER -- requirements
Module: InstructionEncoder

Interface
REQ-001 Parameter MEM_DEPTH, 64, number of instruction-memory words the block may write.
REQ-002 Parameter ADDR_WIDTH, 6, width of mem_addr; SHALL satisfy 2^ADDR_WIDTH >= MEM_DEPTH.
REQ-003 Parameter BASE_ADDR, 0, first word address written after reset or clear.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low; all state cleared while low.
REQ-006 clear  input  1  synchronous restart of program load.
REQ-007 valid_i  input  1  request fields valid this cycle.
REQ-008 ready_o  output  1  block can accept a request this cycle.
REQ-009 last_i  input  1  qualifies the accepted request as the final instruction.
REQ-010 kind_i  input  4  instruction class: 0 R-type, 1 ADDI, 2 ANDI, 3 ORI, 4 LUI, 5 BEQ, 6 BNE, 7 J, 8 JR, 9 LW, 10 SW, 11 JAL; 12-15 invalid.
REQ-011 rs_i, rt_i, rd_i, shamt_i  input  5 each  register/shift fields.
REQ-012 funct_i  input  6  R-type function code.
REQ-013 imm_i  input  16  immediate/branch offset; target_i  input  26  jump target.
REQ-014 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-015 mem_addr  output  ADDR_WIDTH  word address of current write.
REQ-016 mem_wdata  output  32  encoded instruction word.
REQ-017 count_o  output  ADDR_WIDTH+1  number of words written since reset/clear.
REQ-018 done_o, full_o, error_o  output  1 each  program complete, memory full, sticky invalid-kind flag.

Function
REQ-019 Transfer occurs on a rising edge where valid_i=1 and ready_o=1; ready_o SHALL be combinational only from state and clear (ready_o=0 while clear=1).
REQ-020 FSM states: LOAD (ready_o=1), DONE (ready_o=0); reset and clear enter LOAD.
REQ-021 Encoding: opcodes ADDI 0x08, ANDI 0x0C, ORI 0x0D, LUI 0x0F, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03, LW 0x23, SW 0x2B, R-type/JR 0x00.
REQ-022 R-type word = {0x00,rs,rt,rd,shamt,funct}; JR word = {0x00,rs,15'b0,6'h08} ignoring other fields.
REQ-023 I-type word = {op,rs,rt,imm}; LUI forces rs field to 0; J/JAL word = {op,target}.
REQ-024 Latency: transfer at edge N -> mem_we=1 with mem_addr/mem_wdata valid for exactly the cycle after edge N; mem_we=0 otherwise.
REQ-025 Write pointer starts at BASE_ADDR, increments by 1 per valid-kind write; count_o increments in the same cycle mem_we asserts.
REQ-026 Invalid kind (12-15): accepted, no write, pointer/count unchanged, error_o set and held until reset or clear.
REQ-027 When count reaches MEM_DEPTH, full_o=1 and FSM enters DONE; no further writes; pointer SHALL NOT wrap.
REQ-028 Transfer with last_i=1 (valid or invalid kind): that word (if valid) is written, then done_o=1 and FSM enters DONE.
REQ-029 clear in LOAD or DONE: next edge returns pointer to BASE_ADDR, count_o=0, done_o/full_o/error_o=0; a pending registered write from the previous transfer still completes in the current cycle.
REQ-030 Simultaneous clear and valid_i: clear wins, request not accepted.

Reset
REQ-031 While reset=0: state LOAD, pointer=BASE_ADDR, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count_o=0, done_o=full_o=error_o=0.
REQ-032 Reset asserted mid-write SHALL drop mem_we immediately (asynchronously).

Structure
REQ-033 Opcode, funct 0x08 and kind_i encodings SHALL reside in a shared MIPS definitions package also used by the control unit.
REQ-034 The combinational field-to-word encoder SHALL be a sub-module InstructionFormatter; FSM, pointer and output registers stay in InstructionEncoder.

Verification
REQ-035 ADDI rs=0 rt=8 imm=5 after reset -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x20080005, count_o=1.
REQ-036 JR rs=31 funct_i=0x3F -> mem_wdata=0x03E00008; J target=0x0100000 -> 0x08100000.
REQ-037 64 back-to-back valid requests -> addresses 0..63, full_o=1, ready_o=0, 65th request ignored.
REQ-038 kind=13 then ORI -> error_o=1, no write for kind 13, ORI written at address 0.
REQ-039 last_i=1 on third request -> 3 writes, done_o=1; clear with valid_i=1 same cycle -> no accept, count_o=0, ready_o=1 next cycle.
REQ-040 reset pulsed low during mem_we=1 -> mem_we falls without clock edge, all outputs at reset values.

Source files
------------

// File: rtl/instruction_encoder_pkg.sv
// Shared MIPS definitions: instruction-class codes seen on kind_i, primary
// opcodes, the JR function code, and the encoder FSM state type. The control
// unit imports this same package so both sides agree on every encoding.
package instruction_encoder_pkg;

    // Instruction class presented on kind_i; codes 12..15 are invalid.
    typedef enum logic [3:0] {
        KIND_RTYPE = 4'd0,
        KIND_ADDI  = 4'd1,
        KIND_ANDI  = 4'd2,
        KIND_ORI   = 4'd3,
        KIND_LUI   = 4'd4,
        KIND_BEQ   = 4'd5,
        KIND_BNE   = 4'd6,
        KIND_J     = 4'd7,
        KIND_JR    = 4'd8,
        KIND_LW    = 4'd9,
        KIND_SW    = 4'd10,
        KIND_JAL   = 4'd11
    } instrKind_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    // LOAD accepts requests; DONE holds until clear or reset.
    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_DONE = 1'b1
    } encState_t;

endpackage

// File: rtl/instruction_encoder_formatter.sv
// Combinational field-to-word encoder for MIPS instructions.
// Ports:
//   kind                          instruction class (see instrKind_t)
//   rs, rt, rd, shamt, funct      register / shift / function fields
//   imm, target                   immediate and jump target
//   word                          encoded 32-bit instruction (0 when invalid)
//   kindValid                     1 when kind is a defined class
module instruction_encoder_formatter
    import instruction_encoder_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        kindValid
);

    always_comb begin
        word      = '0;
        kindValid = 1'b1;
        case (kind)
            KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            // JR keeps only rs; all other fields are ignored.
            KIND_JR:    word = {OP_RTYPE, rs, 15'b0, FUNCT_JR};
            KIND_ADDI:  word = {OP_ADDI, rs, rt, imm};
            KIND_ANDI:  word = {OP_ANDI, rs, rt, imm};
            KIND_ORI:   word = {OP_ORI,  rs, rt, imm};
            // LUI has no source register, so rs is forced to zero.
            KIND_LUI:   word = {OP_LUI,  5'b0, rt, imm};
            KIND_BEQ:   word = {OP_BEQ,  rs, rt, imm};
            KIND_BNE:   word = {OP_BNE,  rs, rt, imm};
            KIND_LW:    word = {OP_LW,   rs, rt, imm};
            KIND_SW:    word = {OP_SW,   rs, rt, imm};
            KIND_J:     word = {OP_J,    target};
            KIND_JAL:   word = {OP_JAL,  target};
            default:    kindValid = 1'b0;
        endcase
    end

endmodule

// File: rtl/instruction_encoder.sv
// Program loader: accepts instruction field requests, encodes them and writes
// them sequentially into instruction memory starting at BASE_ADDR.
// Handshake: a request transfers on a rising edge where valid_i and ready_o
// are both 1. ready_o depends only on FSM state and clear, never on valid_i.
// Ports:
//   clk, reset (async active-low), clear (sync restart of the load)
//   valid_i/ready_o/last_i          request handshake and end-of-program mark
//   kind_i, rs_i..target_i          instruction fields
//   mem_we/mem_addr/mem_wdata       one-cycle memory write, registered
//   count_o                         words written since reset/clear
//   done_o/full_o/error_o           status flags (error_o is sticky)
//   dbgState                        current FSM state
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int MEM_DEPTH  = 64,
    parameter int ADDR_WIDTH = 6,   // 2**ADDR_WIDTH must cover MEM_DEPTH
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  last_i,
    input  logic [3:0]            kind_i,
    input  logic [4:0]            rs_i,
    input  logic [4:0]            rt_i,
    input  logic [4:0]            rd_i,
    input  logic [4:0]            shamt_i,
    input  logic [5:0]            funct_i,
    input  logic [15:0]           imm_i,
    input  logic [25:0]           target_i,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  done_o,
    output logic                  full_o,
    output logic                  error_o,
    output encState_t             dbgState
);

    localparam logic [ADDR_WIDTH-1:0] BASE_PTR    = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   DEPTH_COUNT = (ADDR_WIDTH+1)'(MEM_DEPTH);

    encState_t             state;
    logic [ADDR_WIDTH-1:0] writePtr;
    logic [ADDR_WIDTH:0]   countNext;
    logic [31:0]           encWord;
    logic                  kindValid;
    logic                  accept;

    instruction_encoder_formatter formatter (
        .kind      (kind_i),
        .rs        (rs_i),
        .rt        (rt_i),
        .rd        (rd_i),
        .shamt     (shamt_i),
        .funct     (funct_i),
        .imm       (imm_i),
        .target    (target_i),
        .word      (encWord),
        .kindValid (kindValid)
    );

    // clear blocks acceptance so a simultaneous request is never taken.
    assign ready_o   = (state == ST_LOAD) && !clear;
    assign accept    = valid_i && ready_o;
    assign countNext = count_o + (ADDR_WIDTH+1)'(1);
    assign dbgState  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_LOAD;
            writePtr  <= BASE_PTR;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_PTR;
            mem_wdata <= '0;
            count_o   <= '0;
            done_o    <= 1'b0;
            full_o    <= 1'b0;
            error_o   <= 1'b0;
        end else begin
            // Write strobe lasts exactly one cycle after the transfer edge.
            mem_we <= 1'b0;
            if (clear) begin
                state    <= ST_LOAD;
                writePtr <= BASE_PTR;
                count_o  <= '0;
                done_o   <= 1'b0;
                full_o   <= 1'b0;
                error_o  <= 1'b0;
            end else if (accept) begin
                if (kindValid) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= writePtr;
                    mem_wdata <= encWord;
                    count_o   <= countNext;
                    // Stop at the last word instead of letting the pointer wrap.
                    if (countNext == DEPTH_COUNT) begin
                        full_o <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        writePtr <= writePtr + ADDR_WIDTH'(1);
                    end
                end else begin
                    error_o <= 1'b1;
                end
                if (last_i) begin
                    done_o <= 1'b1;
                    state  <= ST_DONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;
    import instruction_encoder_pkg::*;

    localparam int EW = 6 + 32 + 7;   // {addr, data, count}

    logic        clk;
    logic        reset;
    logic        clear;
    logic        valid_i;
    logic        ready_o;
    logic        last_i;
    logic [3:0]  kind_i;
    logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
    logic [5:0]  funct_i;
    logic [15:0] imm_i;
    logic [25:0] target_i;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [6:0]  count_o;
    logic        done_o, full_o, error_o;
    encState_t   dbgState;

    logic [EW-1:0] expQ[$];
    int checks;
    int failures;

    instruction_encoder dut (
        .clk(clk), .reset(reset), .clear(clear),
        .valid_i(valid_i), .ready_o(ready_o), .last_i(last_i),
        .kind_i(kind_i), .rs_i(rs_i), .rt_i(rt_i), .rd_i(rd_i),
        .shamt_i(shamt_i), .funct_i(funct_i), .imm_i(imm_i),
        .target_i(target_i), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .count_o(count_o), .done_o(done_o),
        .full_o(full_o), .error_o(error_o), .dbgState(dbgState)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                       input logic [15:0] im, input logic [25:0] tg, input logic lst);
        kind_i   = k;
        rs_i     = rs;
        rt_i     = rt;
        rd_i     = rd;
        shamt_i  = sh;
        funct_i  = fn;
        imm_i    = im;
        target_i = tg;
        last_i   = lst;
        valid_i  = 1'b1;
    endtask

    task automatic idle();
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic pushExp(input logic [5:0] a, input logic [31:0] d, input logic [6:0] c);
        expQ.push_back({a, d, c});
    endtask

    task automatic doClear();
        idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
    endtask

    // scoreboard monitor: every write strobe must match the head of expQ
    always @(negedge clk) begin
        if (reset && mem_we) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr=%0d data=%h, none required", mem_addr, mem_wdata);
            end else begin
                logic [EW-1:0] e;
                e = expQ.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e[EW-1 -: 6]));
                check("wr_data", mem_wdata, e[38:7]);
                check("wr_count", 32'(count_o), 32'(e[6:0]));
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        clear    = 1'b0;
        kind_i   = '0; rs_i = '0; rt_i = '0; rd_i = '0; shamt_i = '0;
        funct_i  = '0; imm_i = '0; target_i = '0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_flags", {29'b0, done_o, full_o, error_o}, 0);
        reset = 1'b1;
        #1;
        check("rst_ready", 32'(ready_o), 1);

        // ADDI, JR (junk fields ignored), J with last
        req(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0005, 26'h0, 1'b0);
        pushExp(6'd0, 32'h20080005, 7'd1);
        tick();
        req(4'd8, 5'd31, 5'd7, 5'd9, 5'd3, 6'h3F, 16'hABCD, 26'h0, 1'b0);
        pushExp(6'd1, 32'h03E00008, 7'd2);
        tick();
        req(4'd7, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0100000, 1'b1);
        pushExp(6'd2, 32'h08100000, 7'd3);
        tick();
        idle();
        check("last_done", 32'(done_o), 1);
        check("last_ready", 32'(ready_o), 0);
        check("last_count", 32'(count_o), 3);

        // request while DONE must be ignored
        req(4'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'h00, 16'h1111, 26'h0, 1'b0);
        tick();
        idle();
        tick();
        check("done_count_held", 32'(count_o), 3);

        // clear with simultaneous valid: clear wins
        clear = 1'b1;
        req(4'd1, 5'd2, 5'd2, 5'd0, 5'd0, 6'h00, 16'h2222, 26'h0, 1'b0);
        #1;
        check("clear_ready_low", 32'(ready_o), 0);
        tick();
        clear = 1'b0;
        idle();
        #1;
        check("clear_count", 32'(count_o), 0);
        check("clear_ready", 32'(ready_o), 1);
        check("clear_done", 32'(done_o), 0);

        // remaining formats from address 0
        req(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 26'h0, 1'b0);
        pushExp(6'd0, 32'h00221820, 7'd1);
        tick();
        req(4'd4, 5'd7, 5'd4, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0, 1'b0);
        pushExp(6'd1, 32'h3C041234, 7'd2);
        tick();
        req(4'd10, 5'd29, 5'd31, 5'd0, 5'd0, 6'h00, 16'hFFFC, 26'h0, 1'b0);
        pushExp(6'd2, 32'hAFBFFFFC, 7'd3);
        tick();
        req(4'd5, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0003, 26'h0, 1'b0);
        pushExp(6'd3, 32'h10220003, 7'd4);
        tick();
        req(4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h3FFFFFF, 1'b0);
        pushExp(6'd4, 32'h0FFFFFFF, 7'd5);
        tick();
        idle();
        tick();

        // invalid kind then ORI
        doClear();
        req(4'd13, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001, 26'h1, 1'b0);
        tick();
        check("inv_count", 32'(count_o), 0);
        req(4'd3, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h00FF, 26'h0, 1'b0);
        pushExp(6'd0, 32'h346400FF, 7'd1);
        tick();
        idle();
        tick();
        check("err_flag", 32'(error_o), 1);
        check("err_count", 32'(count_o), 1);
        doClear();
        check("err_cleared", 32'(error_o), 0);

        // fill all 64 words back-to-back, then one extra
        for (int i = 0; i < 64; i++) begin
            req(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'(i), 26'h0, 1'b0);
            pushExp(6'(i), 32'h20080000 | 32'(i), 7'(i + 1));
            tick();
        end
        req(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h00AA, 26'h0, 1'b0);
        tick();
        idle();
        tick();
        check("full_flag", 32'(full_o), 1);
        check("full_ready", 32'(ready_o), 0);
        check("full_count", 32'(count_o), 64);
        check("full_done", 32'(done_o), 0);
        doClear();
        check("full_cleared", 32'(full_o), 0);

        // async reset during a write strobe
        req(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0077, 26'h0, 1'b0);
        tick();
        idle();
        check("pre_rst_we", 32'(mem_we), 1);
        reset = 1'b0;
        #1;
        check("async_we", 32'(mem_we), 0);
        check("async_addr", 32'(mem_addr), 0);
        check("async_wdata", mem_wdata, 0);
        check("async_count", 32'(count_o), 0);
        check("async_flags", {29'b0, done_o, full_o, error_o}, 0);
        tick();
        reset = 1'b1;
        tick();
        check("queue_empty", 32'(expQ.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
